// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one 64x8 SRAM macro between three requesters
module sram_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic            wb_clk_i,
  input  logic            rst_n,
  input  logic [2:0]      port_en,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      ack,
  output logic [3*DW-1:0] rdata,
  output logic            busy,
  output logic            sram_cen,
  output logic            sram_gwe,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_in,
  input  logic [DW-1:0]   sram_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      cur_q, cur_d;
  logic            cur_we_q, cur_we_d;
  logic [2:0]      ack_q, ack_d;
  logic [3*DW-1:0] rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            cen_q, cen_d;
  logic            gwe_q, gwe_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   in_q, in_d;

  logic [2:0] elig;
  logic [1:0] grant;
  logic [1:0] idx;
  logic       grant_valid;

  // A port acked this cycle is masked so a still-held req cannot retrigger it.
  always_comb begin
    elig        = req & port_en & ~ack_q;
    grant_valid = 1'b0;
    grant       = last_q;
    idx         = last_q;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(last_q) + k) % 3);
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cur_d    = cur_q;
    cur_we_d = cur_we_q;
    ack_d    = 3'b000;
    rdata_d  = rdata_q;
    cen_d    = cen_q;
    gwe_d    = gwe_q;
    addr_d   = addr_q;
    in_d     = in_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          cen_d    = 1'b0;
          gwe_d    = ~we[grant];
          addr_d   = addr[int'(grant)*AW +: AW];
          in_d     = wdata[int'(grant)*DW +: DW];
          cur_d    = grant;
          cur_we_d = we[grant];
          last_d   = grant;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cen_d   = 1'b1;
        gwe_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        // Macro read data is valid in this cycle, one cycle after the access edge.
        ack_d = 3'b001 << cur_q;
        if (!cur_we_q) begin
          rdata_d[int'(cur_q)*DW +: DW] = sram_out;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cen_d   = 1'b1;
        gwe_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= 2'd2;
      cur_q    <= 2'd0;
      cur_we_q <= 1'b0;
      ack_q    <= 3'b000;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      cen_q    <= 1'b1;
      gwe_q    <= 1'b1;
      addr_q   <= '0;
      in_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      cur_we_q <= cur_we_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      cen_q    <= cen_d;
      gwe_q    <= gwe_d;
      addr_q   <= addr_d;
      in_q     <= in_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign sram_cen  = cen_q;
  assign sram_gwe  = gwe_q;
  assign sram_addr = addr_q;
  assign sram_in   = in_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with macro model and transaction scoreboard
module tb_sram_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  port_en, req, we, ack;
  logic [17:0] addr;
  logic [23:0] wdata, rdata;
  logic        busy, sram_cen, sram_gwe;
  logic [5:0]  sram_addr;
  logic [7:0]  sram_in, sram_out;

  sram_arbiter #(.AW(6), .DW(8)) dut (
    .wb_clk_i(clk), .rst_n(rst_n), .port_en(port_en), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy),
    .sram_cen(sram_cen), .sram_gwe(sram_gwe), .sram_addr(sram_addr),
    .sram_in(sram_in), .sram_out(sram_out)
  );

  // Macro model: samples controls on the rising edge, read data appears after it.
  logic       init_done;
  logic [7:0] sram_mem [64];
  logic [7:0] ref_mem [64];

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 37 + 5);
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int m = 0; m < 64; m++) sram_mem[m] <= init_val(m);
    end else if (!sram_cen) begin
      if (!sram_gwe) sram_mem[sram_addr] <= sram_in;
      else           sram_out <= sram_mem[sram_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 3'b000; we = 3'b000; port_en = 3'b111;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       chk;
    logic       rst_n;
    logic [2:0] en, req, we;
    logic [5:0] a;
    logic [7:0] d;
    logic       cen, gwe;
    logic [2:0] ack;
    logic       busy;
    logic [7:0] rd1;
  } vec_t;

  vec_t tbl [11];

  // Random-phase scoreboard state
  logic [2:0] pend;
  logic       p_we [3];
  logic [5:0] p_addr [3];
  logic [7:0] p_wd [3];
  int         waitc [3];
  int         startc [3];
  logic       fair [3];
  logic [23:0] exp_rd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] e3;
    init_done = 1'b0; rst_n = 1'b0; port_en = 3'b000; req = 3'b000; we = 3'b000;
    addr = '0; wdata = '0;
    next_cycle();
    init_done = 1'b1;

    // Reset, then port 1 write 2A<=C3 and read back
    tbl[0]  = '{1'b0, 1'b0, 3'b111, 3'b111, 3'b000, 6'h00, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 3'b111, 3'b111, 3'b000, 6'h00, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 3'b111, 3'b010, 3'b010, 6'h2A, 8'hC3, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 3'b111, 3'b010, 3'b010, 6'h2A, 8'hC3, 1'b0, 1'b0, 3'b000, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 3'b111, 3'b010, 3'b010, 6'h2A, 8'hC3, 1'b1, 1'b1, 3'b000, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 6'h2A, 8'h00, 1'b1, 1'b1, 3'b010, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 1'b1, 3'b111, 3'b010, 3'b000, 6'h2A, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 1'b1, 3'b111, 3'b010, 3'b000, 6'h2A, 8'h00, 1'b0, 1'b1, 3'b000, 1'b1, 8'h00};
    tbl[8]  = '{1'b1, 1'b1, 3'b111, 3'b010, 3'b000, 6'h2A, 8'h00, 1'b1, 1'b1, 3'b000, 1'b1, 8'h00};
    tbl[9]  = '{1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 6'h2A, 8'h00, 1'b1, 1'b1, 3'b010, 1'b0, 8'hC3};
    tbl[10] = '{1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 6'h2A, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 8'hC3};

    for (int r = 0; r < 11; r++) begin
      rst_n = tbl[r].rst_n; port_en = tbl[r].en; req = tbl[r].req; we = tbl[r].we;
      addr = {3{tbl[r].a}}; wdata = {3{tbl[r].d}};
      @(negedge clk);
      if (tbl[r].chk) begin
        check($sformatf("tbl%0d_cen", r), 32'(sram_cen), 32'(tbl[r].cen));
        check($sformatf("tbl%0d_gwe", r), 32'(sram_gwe), 32'(tbl[r].gwe));
        check($sformatf("tbl%0d_ack", r), 32'(ack), 32'(tbl[r].ack));
        check($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
        check($sformatf("tbl%0d_rdata", r), 32'(rdata), 32'({8'h00, tbl[r].rd1, 8'h00}));
      end
      next_cycle();
    end

    // Contention: three reads from reset, grants 0,1,2,0
    do_reset();
    req = 3'b111; we = 3'b000; addr = {6'd12, 6'd11, 6'd10};
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      e3 = (c == 3 || c == 12) ? 3'b001 : (c == 6) ? 3'b010 : (c == 9) ? 3'b100 : 3'b000;
      check($sformatf("contend_ack_c%0d", c), 32'(ack), 32'(e3));
      if (c == 12)
        check("contend_rdata", 32'(rdata), 32'({init_val(12), init_val(11), init_val(10)}));
      next_cycle();
    end

    // Held request on port 2 alone: one ack every 4 cycles
    do_reset();
    req = 3'b100; we = 3'b000; addr = {6'd5, 12'd0};
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      e3 = (c >= 3 && (c - 3) % 4 == 0) ? 3'b100 : 3'b000;
      check($sformatf("held_ack_c%0d", c), 32'(ack), 32'(e3));
      next_cycle();
    end

    // Port 1 disabled: ports 0 and 2 alternate
    do_reset();
    port_en = 3'b101; req = 3'b111; we = 3'b000; addr = {6'd20, 6'd21, 6'd22};
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      e3 = (c > 0 && c % 3 == 0) ? (((c / 3) % 2 == 1) ? 3'b001 : 3'b100) : 3'b000;
      check($sformatf("en101_ack_c%0d", c), 32'(ack), 32'(e3));
      next_cycle();
    end

    // Reset during ACCESS of a port 0 write
    do_reset();
    req = 3'b001; we = 3'b001; addr = {12'd0, 6'h30}; wdata = {16'd0, 8'h5A};
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("midrst_access_cen", 32'(sram_cen), 32'(1'b0));
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1; req = 3'b000; we = 3'b000;
    @(negedge clk);
    check("midrst_cen", 32'(sram_cen), 32'(1'b1));
    check("midrst_busy", 32'(busy), 32'(1'b0));
    for (int c = 0; c < 4; c++) begin
      check($sformatf("midrst_ack%0d", c), 32'(ack), 32'(3'b000));
      next_cycle();
      @(negedge clk);
    end
    next_cycle();

    // Randomised traffic against a transaction-level scoreboard
    do_reset();
    for (int m = 0; m < 64; m++) ref_mem[m] = sram_mem[m];
    exp_rd = '0; pend = 3'b000;
    for (int i = 0; i < 3; i++) begin waitc[i] = 0; startc[i] = 0; fair[i] = 1'b0; end
    for (int cyc = 0; cyc < 660; cyc++) begin
      if (cyc >= 300 && cyc < 600 && cyc % 16 == 0) begin
        port_en = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) fair[i] = 1'b0;
      end
      if (cyc == 600) port_en = 3'b111;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && cyc < 600 && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1; p_we[i] = 1'($urandom_range(0, 1));
          p_addr[i] = 6'($urandom_range(0, 63)); p_wd[i] = 8'($urandom);
          waitc[i] = 0; startc[i] = cyc; fair[i] = (cyc < 300);
        end
        req[i] = pend[i]; we[i] = p_we[i];
        addr[i*6 +: 6] = p_addr[i]; wdata[i*8 +: 8] = p_wd[i];
      end
      @(negedge clk);
      check("rand_ack_onehot", 32'($countones(ack) <= 1), 32'd1);
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) begin
          check($sformatf("rand_ack_pending_p%0d", i), 32'(pend[i]), 32'd1);
          if (pend[i]) begin
            if (fair[i]) check($sformatf("rand_fair_p%0d", i), 32'(waitc[i] <= 2), 32'd1);
            if (p_we[i]) ref_mem[p_addr[i]] = p_wd[i];
            else         exp_rd[i*8 +: 8] = ref_mem[p_addr[i]];
            pend[i] = 1'b0;
          end
          for (int j = 0; j < 3; j++)
            if (j != i && pend[j] && startc[j] < cyc) waitc[j]++;
        end
      end
      check("rand_rdata", 32'(rdata), 32'(exp_rd));
      check("rand_gwe_cen", 32'(!sram_gwe && sram_cen), 32'd0);
      next_cycle();
    end
    check("rand_drain", 32'(pend), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single 64x8 user-area SRAM macro between three requesters: the Wishbone management path (port 0), wrapped_qcpu (port 1) and wrapped_mc14500 (port 2). It sits between the requesters and the macro, replacing direct wiring of qcpu_sram_*/mc14500_sram_* to the macro. It serialises accesses with round-robin arbitration and returns per-port read data with a one-cycle ack pulse.

## Interface
Parameters:
- AW, 6, SRAM address width
- DW, 8, SRAM data width

Ports:
- wb_clk_i  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- port_en  in  3  per-port enable; a disabled port's req is ignored
- req  in  3  per-port request, level; held with its addr/we/wdata until that port's ack
- we  in  3  per-port write (1) / read (0)
- addr  in  3*AW  packed; port i at [i*AW +: AW]
- wdata  in  3*DW  packed; port i at [i*DW +: DW]
- ack  out  3  one-cycle completion pulse per port
- rdata  out  3*DW  packed per-port read data register; updated only on that port's read ack
- busy  out  1  high in ACCESS and RESP
- sram_cen  out  1  macro chip enable, active-low
- sram_gwe  out  1  macro write enable, active-low
- sram_addr  out  AW  macro address
- sram_in  out  DW  macro write data
- sram_out  in  DW  macro read data, valid the cycle after the access edge

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset: state=IDLE, sram_cen=1, sram_gwe=1, sram_addr=0, sram_in=0, ack=0, rdata=0, busy=0, last=2.
- Eligible set e = req & port_en & ~ack (a port whose ack is high this cycle is masked, so held req does not retrigger).
- IDLE: if e!=0, choose winner w = first set bit of e searching last+1, last+2, last+3 (mod 3); register sram_cen=0, sram_gwe=~we[w], sram_addr=addr[w], sram_in=wdata[w], cur=w, last=w; go ACCESS. Else stay IDLE.
- ACCESS: macro samples controls at the edge ending this cycle; register sram_cen=1, sram_gwe=1 (addr/data hold); go RESP.
- RESP: go IDLE; ack[cur]=1 for the next cycle; if access was a read, rdata[cur]=sram_out; on write rdata[cur] unchanged.
- Ports disabled while their transaction is in flight still complete (ack issued). Req dropped mid-transaction is not cancelled; ack still issued.
- Round-robin guarantees each continuously requesting enabled port is served within 3 transactions.
- No write/read merging, no back-to-back pipelining.

## Timing
- Outputs all registered; no combinational input-to-output path.
- Request seen in IDLE cycle T: sram_cen low in T+1, ack high in T+3, rdata valid from T+3. Throughput: one access per 3 cycles while any port eligible (ack cycle is IDLE and can accept another port).
- Same port re-issuing: req kept high through ack cycle is masked; new transaction earliest accepted in T+4.
- Simultaneous reqs in one cycle: resolved by round-robin order above; losers wait, no ack.
- rst_n low on any edge overrides everything: next cycle reset values, in-flight transaction discarded, no ack.

## Test plan
- Reset: drive rst_n=0 two cycles with req=3'b111 -> sram_cen=1, sram_gwe=1, ack=0, busy=0, rdata=0.
- Single write/read port 1: write addr 6'h2A data 8'hC3, then read 6'h2A -> write ack[1] at T+3 with sram_gwe=0 in T+1; read ack[1] at T+3 with rdata[15:8]=8'hC3; other ack bits stay 0.
- Contention: req=3'b111 from reset, all reads of distinct preloaded addresses -> grants in order 0,1,2,0 with acks at cycles 3,6,9,12; each rdata slot matches its own address contents.
- Held req: port 2 keeps req high continuously alone -> one transaction per 4 cycles, acks never on consecutive cycles.
- port_en=3'b101 with req=3'b111 -> port 1 never acked; ports 0 and 2 alternate.
- Reset mid-op: assert rst_n=0 during ACCESS of a port 0 write -> no ack[0], state IDLE, sram_cen=1 next cycle.
